// File: rtl/hps_cmd_master.sv
`default_nettype none
// ============================================================================
// hps_cmd_master : host-side HPS command bus initiator (status/joystick/file)
// Revision 1.0
// ============================================================================
module hps_cmd_master #(
   parameter int          STROBE_GAP = 2,
   parameter int          XACT_GAP   = 4,
   parameter logic [15:0] CMD_STATUS = 16'h001E,
   parameter logic [15:0] CMD_JOY0   = 16'h0002,
   parameter logic [15:0] CMD_JOY1   = 16'h0003,
   parameter logic [15:0] CMD_FIDX   = 16'h0055,
   parameter logic [15:0] CMD_FTX    = 16'h0053,
   parameter logic [15:0] CMD_FDAT   = 16'h0054
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_type,
   input  logic [63:0] req_data,
   input  logic        dl_valid,
   output logic        dl_ready,
   input  logic [7:0]  dl_data,
   input  logic        dl_last,
   output logic        io_enable,
   output logic        io_strobe,
   output logic [15:0] io_din,
   input  logic        io_wait,
   output logic        busy
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_OPEN      = 4'd1;
   localparam logic [3:0] S_CMD       = 4'd2;
   localparam logic [3:0] S_DATA      = 4'd3;
   localparam logic [3:0] S_GAP       = 4'd4;
   localparam logic [3:0] S_DL_IDX    = 4'd5;
   localparam logic [3:0] S_DL_START  = 4'd6;
   localparam logic [3:0] S_DL_STREAM = 4'd7;
   localparam logic [3:0] S_DL_END    = 4'd8;

   localparam int SG_W = $clog2(STROBE_GAP + 1);
   localparam int XG_W = $clog2(XACT_GAP + 1);

   logic [3:0]      state_q, state_d;
   logic            req_ready_q, req_ready_d;
   logic            busy_q, busy_d;
   logic            io_enable_q, io_enable_d;
   logic            io_strobe_q, io_strobe_d;
   logic [15:0]     io_din_q, io_din_d;
   logic [1:0]      type_q, type_d;
   logic [63:0]     data_q, data_d;
   logic [1:0]      word_idx_q, word_idx_d;
   logic [1:0]      frame_q, frame_d;
   logic [SG_W-1:0] sgap_q, sgap_d;
   logic [XG_W-1:0] xgap_q, xgap_d;
   logic [7:0]      lo_byte_q, lo_byte_d;
   logic            have_lo_q, have_lo_d;
   logic            full_q, full_d;
   logic [15:0]     pack_q, pack_d;
   logic            pack_last_q, pack_last_d;

   logic            w_can_strobe;
   logic            w_dl_ready;
   logic [15:0]     w_cmd_word;
   logic [15:0]     w_data_word;
   logic            issue;
   logic [15:0]     issue_word;
   logic            to_gap;

   // io_wait is sampled here, one cycle ahead of the registered strobe.
   assign w_can_strobe = (sgap_q == '0) && !io_wait;
   assign w_dl_ready   = (state_q == S_DL_STREAM) && !full_q;
   assign w_data_word  = data_q[{word_idx_q, 4'b0000} +: 16];

   always_comb begin
      w_cmd_word = CMD_STATUS;
      case (type_q)
         2'd0:    w_cmd_word = CMD_STATUS;
         2'd1:    w_cmd_word = CMD_JOY0;
         2'd2:    w_cmd_word = CMD_JOY1;
         default: begin
            case (frame_q)
               2'd0:    w_cmd_word = CMD_FIDX;
               2'd2:    w_cmd_word = CMD_FDAT;
               default: w_cmd_word = CMD_FTX;
            endcase
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      io_enable_d = io_enable_q;
      io_strobe_d = 1'b0;
      io_din_d    = io_din_q;
      type_d      = type_q;
      data_d      = data_q;
      word_idx_d  = word_idx_q;
      frame_d     = frame_q;
      sgap_d      = sgap_q;
      xgap_d      = xgap_q;
      lo_byte_d   = lo_byte_q;
      have_lo_d   = have_lo_q;
      full_d      = full_q;
      pack_d      = pack_q;
      pack_last_d = pack_last_q;
      issue       = 1'b0;
      issue_word  = io_din_q;
      to_gap      = 1'b0;

      if (sgap_q != '0) begin
         sgap_d = sgap_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (req_ready_q && req_valid) begin
               type_d      = req_type;
               data_d      = req_data;
               frame_d     = 2'd0;
               io_enable_d = 1'b1;
               state_d     = S_OPEN;
            end
         end
         S_OPEN: begin
            state_d = S_CMD;
         end
         S_CMD: begin
            if (w_can_strobe) begin
               issue      = 1'b1;
               issue_word = w_cmd_word;
               word_idx_d = 2'd0;
               if (type_q != 2'd3) begin
                  state_d = S_DATA;
               end else begin
                  case (frame_q)
                     2'd0: state_d = S_DL_IDX;
                     2'd1: state_d = S_DL_START;
                     2'd2: begin
                        state_d     = S_DL_STREAM;
                        have_lo_d   = 1'b0;
                        full_d      = 1'b0;
                        pack_last_d = 1'b0;
                     end
                     default: state_d = S_DL_END;
                  endcase
               end
            end
         end
         S_DATA: begin
            if (w_can_strobe) begin
               issue      = 1'b1;
               issue_word = w_data_word;
               if ((type_q != 2'd0) || (word_idx_q == 2'd3)) begin
                  to_gap = 1'b1;
               end else begin
                  word_idx_d = word_idx_q + 2'd1;
               end
            end
         end
         S_DL_IDX: begin
            if (w_can_strobe) begin
               issue      = 1'b1;
               issue_word = {8'h00, data_q[7:0]};
               to_gap     = 1'b1;
            end
         end
         S_DL_START: begin
            if (w_can_strobe) begin
               issue      = 1'b1;
               issue_word = 16'h00FF;
               to_gap     = 1'b1;
            end
         end
         S_DL_STREAM: begin
            if (full_q) begin
               if (w_can_strobe) begin
                  issue      = 1'b1;
                  issue_word = pack_q;
                  full_d     = 1'b0;
                  to_gap     = pack_last_q;
               end
            end else if (dl_valid) begin
               // Little-endian packing; a lone final byte is sent zero-extended.
               if (have_lo_q) begin
                  pack_d      = {dl_data, lo_byte_q};
                  full_d      = 1'b1;
                  pack_last_d = dl_last;
                  have_lo_d   = 1'b0;
               end else if (dl_last) begin
                  pack_d      = {8'h00, dl_data};
                  full_d      = 1'b1;
                  pack_last_d = 1'b1;
               end else begin
                  lo_byte_d = dl_data;
                  have_lo_d = 1'b1;
               end
            end
         end
         S_DL_END: begin
            if (w_can_strobe) begin
               issue      = 1'b1;
               issue_word = 16'h0000;
               to_gap     = 1'b1;
            end
         end
         S_GAP: begin
            io_enable_d = 1'b0;
            if (xgap_q != '0) begin
               xgap_d = xgap_q - 1'b1;
            end else if ((type_q == 2'd3) && (frame_q != 2'd3)) begin
               frame_d     = frame_q + 2'd1;
               io_enable_d = 1'b1;
               state_d     = S_OPEN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            io_enable_d = 1'b0;
         end
      endcase

      // The GAP state begins on the final strobe cycle, so io_enable falls right after it.
      if (to_gap) begin
         state_d = S_GAP;
         xgap_d  = XG_W'(XACT_GAP);
      end

      if (issue) begin
         io_strobe_d = 1'b1;
         io_din_d    = issue_word;
         sgap_d      = SG_W'(STROBE_GAP);
      end

      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         io_enable_q <= 1'b0;
         io_strobe_q <= 1'b0;
         io_din_q    <= 16'h0000;
         type_q      <= 2'd0;
         data_q      <= 64'd0;
         word_idx_q  <= 2'd0;
         frame_q     <= 2'd0;
         sgap_q      <= '0;
         xgap_q      <= '0;
         lo_byte_q   <= 8'h00;
         have_lo_q   <= 1'b0;
         full_q      <= 1'b0;
         pack_q      <= 16'h0000;
         pack_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         io_enable_q <= io_enable_d;
         io_strobe_q <= io_strobe_d;
         io_din_q    <= io_din_d;
         type_q      <= type_d;
         data_q      <= data_d;
         word_idx_q  <= word_idx_d;
         frame_q     <= frame_d;
         sgap_q      <= sgap_d;
         xgap_q      <= xgap_d;
         lo_byte_q   <= lo_byte_d;
         have_lo_q   <= have_lo_d;
         full_q      <= full_d;
         pack_q      <= pack_d;
         pack_last_q <= pack_last_d;
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign io_enable = io_enable_q;
   assign io_strobe = io_strobe_q;
   assign io_din    = io_din_q;
   assign dl_ready  = w_dl_ready;

endmodule
`default_nettype wire

// File: tb/tb_hps_cmd_master.sv
`default_nettype none
// ============================================================================
// tb_hps_cmd_master : scoreboard bench for hps_cmd_master (directed + random)
// Revision 1.0
// ============================================================================
module tb_hps_cmd_master;

   localparam int SG = 3;
   localparam int XG = 4;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_type = 2'd0;
   logic [63:0] req_data = 64'd0;
   logic        dl_valid, dl_ready, dl_last;
   logic [7:0]  dl_data;
   logic        io_enable, io_strobe, io_wait = 1'b0;
   logic [15:0] io_din;
   logic        busy;

   always #5 clk_sys = ~clk_sys;

   hps_cmd_master #(.STROBE_GAP(SG), .XACT_GAP(XG)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_data(req_data),
      .dl_valid(dl_valid), .dl_ready(dl_ready), .dl_data(dl_data), .dl_last(dl_last),
      .io_enable(io_enable), .io_strobe(io_strobe), .io_din(io_din), .io_wait(io_wait),
      .busy(busy)
   );

   typedef struct {
      logic [15:0] word;
      int          pos;
   } exp_t;

   exp_t       exp_q[$];
   logic [8:0] dl_q[$];
   logic [7:0] cur_bytes[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   bit rand_wait = 1'b0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int req);
      vectors++;
      if (act < req) begin
         miscompares++;
         $display("FAIL %s: got %0d, required >= %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_word(input logic [15:0] w, input int pos);
      exp_t e;
      e.word = w;
      e.pos  = pos;
      exp_q.push_back(e);
   endtask

   // Reference model: the word sequence each request should produce, frame by frame.
   task automatic model_push(input logic [1:0] t, input logic [63:0] d);
      int p;
      case (t)
         2'd0: begin
            push_word(16'h001E, 0);
            for (int i = 0; i < 4; i++) push_word(d[16*i +: 16], i + 1);
         end
         2'd1: begin push_word(16'h0002, 0); push_word(d[15:0], 1); end
         2'd2: begin push_word(16'h0003, 0); push_word(d[15:0], 1); end
         default: begin
            push_word(16'h0055, 0); push_word({8'h00, d[7:0]}, 1);
            push_word(16'h0053, 0); push_word(16'h00FF, 1);
            push_word(16'h0054, 0);
            p = 1;
            for (int i = 0; i < cur_bytes.size(); i += 2) begin
               if (i + 1 < cur_bytes.size()) push_word({cur_bytes[i+1], cur_bytes[i]}, p);
               else push_word({8'h00, cur_bytes[i]}, p);
               p++;
            end
            push_word(16'h0053, 0); push_word(16'h0000, 1);
         end
      endcase
   endtask

   // Drive one request (call just after a rising edge); model is pushed before the accept edge.
   task automatic issue_req(input logic [1:0] t, input logic [63:0] d, input bit keep_valid);
      bit ok = 1'b0;
      if (t == 2'd3)
         for (int i = 0; i < cur_bytes.size(); i++)
            dl_q.push_back({(i == cur_bytes.size() - 1), cur_bytes[i]});
      req_type  = t;
      req_data  = d;
      req_valid = 1'b1;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk_sys);
         if (req_ready) ok = 1'b1;
      end
      if (!ok) check("req_accept_timeout", 0, 1);
      else model_push(t, d);
      @(posedge clk_sys);
      #1;
      req_valid = keep_valid;
   endtask

   task automatic wait_strobe(output int at, output bit ok);
      ok = 1'b0;
      at = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_sys);
         if (io_strobe) begin
            at = cyc;
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk_sys);
         if (req_ready && exp_q.size() == 0) ok = 1'b1;
      end
      check(name, ok, 1);
      @(posedge clk_sys);
      #1;
   endtask

   // Download byte source; drives noise on dl_* whenever no file bytes are pending.
   initial begin
      bit acc;
      dl_valid = 1'b0;
      dl_data  = 8'h00;
      dl_last  = 1'b0;
      forever begin
         @(negedge clk_sys);
         acc = dl_valid && dl_ready && !reset;
         if (!reset && dl_q.size() == 0) check("dl_ready_without_file", dl_ready, 0);
         @(posedge clk_sys);
         #1;
         if (acc && dl_q.size() > 0) void'(dl_q.pop_front());
         if (dl_q.size() > 0) begin
            dl_valid = ($urandom_range(0, 3) != 0);
            dl_data  = dl_q[0][7:0];
            dl_last  = dl_q[0][8];
         end else begin
            dl_valid = ($urandom_range(0, 3) == 0);
            dl_data  = 8'($urandom);
            dl_last  = 1'($urandom);
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk_sys);
         #1;
         if (rand_wait) io_wait = ($urandom_range(0, 4) == 0);
      end
   end

   // Monitor: frame shape, strobe spacing, wait rule, din stability and scoreboard pops.
   initial begin
      int pos = 0, last_cyc = 0, low_cnt = 0;
      bit have_last = 1'b0, had_fall = 1'b0, prev_en = 1'b0, prev_wait = 1'b0;
      logic [15:0] last_din = 16'h0000;
      exp_t e;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            pos = 0; have_last = 1'b0; had_fall = 1'b0; prev_en = 1'b0;
            last_din = 16'h0000; low_cnt = 0;
         end else begin
            if (io_enable && !prev_en) begin
               if (had_fall) check_ge("xact_gap", low_cnt, XG);
               pos = 0;
            end
            if (!io_enable && prev_en) begin
               had_fall = 1'b1;
               low_cnt  = 0;
               if (exp_q.size() > 0) check("frame_end_pos", 64'(exp_q[0].pos), 0);
            end
            if (!io_enable) low_cnt++;
            if (io_strobe) begin
               check("strobe_in_frame", io_enable, 1);
               check("wait_before_strobe", prev_wait, 0);
               if (have_last) check_ge("strobe_spacing", cyc - last_cyc - 1, SG);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_strobe: got io_din %0h, required no strobe", io_din);
               end else begin
                  e = exp_q.pop_front();
                  check("io_din", io_din, e.word);
                  check("strobe_pos", 64'(pos), 64'(e.pos));
               end
               pos++;
               last_cyc  = cyc;
               have_last = 1'b1;
               last_din  = io_din;
            end else begin
               check("io_din_hold", io_din, last_din);
            end
            if (req_ready) check("ready_only_idle", busy, 0);
            if (io_enable) check("busy_in_frame", busy, 1);
         end
         prev_en   = io_enable;
         prev_wait = io_wait;
      end
   end

   initial begin
      int  at, drop_cyc, n;
      bit  ok;
      logic [1:0]  t;
      logic [63:0] d;

      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check("reset_outputs", {io_enable, io_strobe, io_din, req_ready, dl_ready, busy}, 0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("ready_after_reset", {req_ready, busy}, 2'b10);
      @(posedge clk_sys);
      #1;

      // Status request
      issue_req(2'd0, 64'h0000_0020_0000_0000, 1'b0);
      wait_idle("status_done");

      // Joystick 1 with io_wait held for 10 cycles after the command strobe
      issue_req(2'd2, 64'h41, 1'b0);
      wait_strobe(at, ok);
      check("joy1_cmd_seen", ok, 1);
      @(posedge clk_sys);
      #1 io_wait = 1'b1;
      repeat (10) @(posedge clk_sys);
      #1 io_wait = 1'b0;
      drop_cyc = cyc;
      wait_strobe(at, ok);
      check("joy1_data_seen", ok, 1);
      check("joy1_data_cycle", 64'(at), 64'(drop_cyc + 1));
      wait_idle("joy1_done");

      // Download index 3, bytes 11 22 33
      cur_bytes = '{8'h11, 8'h22, 8'h33};
      issue_req(2'd3, 64'h3, 1'b0);
      wait_idle("download_done");

      // Back-to-back joystick 0 with req_valid held
      issue_req(2'd1, 64'h1234, 1'b1);
      issue_req(2'd1, 64'hBEEF, 1'b0);
      wait_idle("b2b_done");

      // Reset during the data phase of a status request
      issue_req(2'd0, 64'h1111_2222_3333_4444, 1'b0);
      n = 0;
      for (int i = 0; i < 2; i++) begin
         wait_strobe(at, ok);
         if (ok) n++;
      end
      check("status_two_strobes", 64'(n), 2);
      @(posedge clk_sys);
      #1 reset = 1'b1;
      exp_q.delete();
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("abort_outputs", {io_enable, io_strobe, req_ready}, 0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      check("idle_after_abort", {req_ready, busy, io_enable}, 3'b100);
      repeat (20) @(posedge clk_sys);
      #1;

      // Randomized traffic with random back-pressure
      rand_wait = 1'b1;
      for (int k = 0; k < 30; k++) begin
         t = 2'($urandom_range(0, 3));
         d = {$urandom, $urandom};
         cur_bytes.delete();
         if (t == 2'd3)
            for (int i = 0; i < $urandom_range(1, 7); i++) cur_bytes.push_back(8'($urandom));
         issue_req(t, d, 1'b0);
         repeat ($urandom_range(0, 3)) @(posedge clk_sys);
         #1;
      end
      wait_idle("random_done");
      rand_wait = 1'b0;
      io_wait   = 1'b0;
      repeat (10) @(posedge clk_sys);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
